serial_comparator: RTL and testbench

Bit-serial WIDTH-bit magnitude comparator. It captures two unsigned operands on a start strobe and walks them MSB-first, one bit per clock, through a single-bit less/equal/greater cell. It reports one-hot L/E/G results with a done pulse. It is the sequential, multi-bit consumer of the team's single-bit comparator cell, and is used where area matters more than latency.

---
 rtl/serial_cmp_pkg.sv | 23 ++
 rtl/serial_comparator_if.sv | 23 ++
 rtl/bit_comparator.sv | 12 +
 rtl/serial_comparator.sv | 115 +++++++++++
 tb/tb_serial_comparator.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_cmp_pkg.sv
// rtl/serial_cmp_pkg.sv - shared state enum and one-hot L/E/G result encoding for serial_comparator
package serial_cmp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Result bits are ordered {L, E, G}
  localparam logic [2:0] RES_NONE = 3'b000;
  localparam logic [2:0] RES_L    = 3'b100;
  localparam logic [2:0] RES_E    = 3'b010;
  localparam logic [2:0] RES_G    = 3'b001;

  function automatic logic [2:0] res_encode(input logic decided, input logic lt, input logic gt);
    if (!decided) return RES_E;
    else if (lt)  return RES_L;
    else if (gt)  return RES_G;
    else          return RES_NONE;
  endfunction

endpackage

// File: rtl/serial_comparator_if.sv
// rtl/serial_comparator_if.sv - request/result bundle between a requester and serial_comparator
interface serial_comparator_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             L;
  logic             E;
  logic             G;

  modport master (
    output start, a, b,
    input  busy, done, L, E, G
  );

  modport slave (
    input  start, a, b,
    output busy, done, L, E, G
  );
endinterface

// File: rtl/bit_comparator.sv
// rtl/bit_comparator.sv - single-bit less/equal/greater comparator cell
module bit_comparator (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);
  assign lt = ~a & b;
  assign eq = ~(a ^ b);
  assign gt = a & ~b;
endmodule

// File: rtl/serial_comparator.sv
// rtl/serial_comparator.sv - bit-serial MSB-first magnitude comparator; SERIAL_CMP_EARLY_EXIT_EN ends on first differing bit
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  serial_comparator_if.slave  bus
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  state_t           state, state_n;
  logic [WIDTH-1:0] sh_a, sh_a_n;
  logic [WIDTH-1:0] sh_b, sh_b_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             decided, decided_n;
  logic             lt_q, lt_n;
  logic             gt_q, gt_n;
  logic [2:0]       res, res_n;

  logic cell_lt, cell_eq, cell_gt;
  logic new_diff;
  logic last_bit;

  bit_comparator u_cell (
    .a  (sh_a[WIDTH-1]),
    .b  (sh_b[WIDTH-1]),
    .lt (cell_lt),
    .eq (cell_eq),
    .gt (cell_gt)
  );

  // Only the first differing bit (from the MSB) decides the outcome
  assign new_diff = (state == SHIFT) && !decided && !cell_eq;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign last_bit = (cnt == '0) || new_diff;
`else
  assign last_bit = (cnt == '0);
`endif

  always_comb begin
    state_n   = state;
    sh_a_n    = sh_a;
    sh_b_n    = sh_b;
    cnt_n     = cnt;
    decided_n = decided;
    lt_n      = lt_q;
    gt_n      = gt_q;
    res_n     = res;

    case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          sh_a_n    = bus.a;
          sh_b_n    = bus.b;
          cnt_n     = CW'(WIDTH - 1);
          decided_n = 1'b0;
          lt_n      = 1'b0;
          gt_n      = 1'b0;
          state_n   = SHIFT;
        end else begin
          state_n   = IDLE;
        end
      end
      SHIFT: begin
        if (new_diff) begin
          lt_n      = cell_lt;
          gt_n      = cell_gt;
          decided_n = 1'b1;
        end
        sh_a_n = {sh_a[WIDTH-2:0], 1'b0};
        sh_b_n = {sh_b[WIDTH-2:0], 1'b0};
        cnt_n  = cnt - 1'b1;
        // Result register is loaded on entry to DONE so it is valid with the done pulse
        if (last_bit) begin
          state_n = DONE;
          res_n   = res_encode(decided_n, lt_n, gt_n);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      res     <= RES_NONE;
    end else begin
      state   <= state_n;
      sh_a    <= sh_a_n;
      sh_b    <= sh_b_n;
      cnt     <= cnt_n;
      decided <= decided_n;
      lt_q    <= lt_n;
      gt_q    <= gt_n;
      res     <= res_n;
    end
  end

  assign bus.busy = (state == SHIFT);
  assign bus.done = (state == DONE);
  assign bus.L    = res[2];
  assign bus.E    = res[1];
  assign bus.G    = res[0];

endmodule

// File: tb/tb_serial_comparator.sv
// tb/tb_serial_comparator.sv - randomized self-checking bench for serial_comparator with reference model
module tb_serial_comparator;
  import serial_cmp_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  serial_comparator_if #(.WIDTH(WIDTH)) bus ();

  serial_comparator #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] model_res(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    if (a < b)       return RES_L;
    else if (a > b)  return RES_G;
    else             return RES_E;
  endfunction

  function automatic int model_lat(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int j = WIDTH - 1; j >= 0; j--)
      if (a[j] != b[j]) return WIDTH - j + 1;
`endif
    return WIDTH + 1;
  endfunction

  function automatic logic [2:0] outs();
    return {bus.L, bus.E, bus.G};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  // Presents a request at a negedge; cycle 0 is the accepting edge, returns at cycle 1
  task automatic launch(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    bus.start = 1'b1;
    bus.a     = a;
    bus.b     = b;
    cyc       = 0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int at, output logic [2:0] r, output logic busy_ok);
    int guard = 0;
    busy_ok = 1'b1;
    while (!bus.done && guard < 4 * WIDTH) begin
      if (!bus.busy) busy_ok = 1'b0;
      tick();
      guard++;
    end
    at = bus.done ? cyc : -1;
    r  = outs();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, outs()} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset busy/done/LEG actual=%b required=00000", {bus.busy, bus.done, outs()});
    end
    tick();
    n_tests++;
    if ({bus.busy, bus.done, outs()} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_idle busy/done/LEG actual=%b required=00000", {bus.busy, bus.done, outs()});
    end
  endtask

  task automatic test_directed(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string name);
    int at;
    logic [2:0] r;
    logic busy_ok;
    launch(a, b);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL %s busy_at_cycle1 actual=%b required=1", name, bus.busy);
    end
    wait_done(at, r, busy_ok);
    n_tests++;
    if (at !== model_lat(a, b)) begin
      n_fail++;
      $display("FAIL %s done_cycle actual=%0d required=%0d", name, at, model_lat(a, b));
    end
    n_tests++;
    if (r !== model_res(a, b) || bus.busy !== 1'b0 || !busy_ok) begin
      n_fail++;
      $display("FAIL %s LEG/busy actual=%b/%b/%b required=%b/0/1", name, r, bus.busy, busy_ok, model_res(a, b));
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || outs() !== model_res(a, b)) begin
      n_fail++;
      $display("FAIL %s hold_after_done actual=%b/%b required=0/%b", name, bus.done, outs(), model_res(a, b));
    end
  endtask

  task automatic test_random(input int n);
    logic [WIDTH-1:0] a, b;
    int at;
    logic [2:0] r;
    logic busy_ok;
    for (int i = 0; i < n; i++) begin
      a = WIDTH'($urandom);
      b = (i % 4 == 0) ? a : WIDTH'($urandom);
      if (i % 4 == 1) b = a ^ WIDTH'(1 << $urandom_range(WIDTH - 1, 0));
      launch(a, b);
      wait_done(at, r, busy_ok);
      n_tests++;
      if (at !== model_lat(a, b) || r !== model_res(a, b) || !busy_ok) begin
        n_fail++;
        $display("FAIL random a=%h b=%h cycle/LEG/busy actual=%0d/%b/%b required=%0d/%b/1",
                 a, b, at, r, busy_ok, model_lat(a, b), model_res(a, b));
      end
      if (i % 3 == 0) tick();
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2;
    launch(8'd3, 8'd4);
    d1 = model_lat(8'd3, 8'd4);
    d2 = d1 + model_lat(8'd9, 8'd9);
    while (cyc < d1) begin
      bus.start = (cyc == 3);
      bus.a = 8'hFF;
      bus.b = 8'h00;
      if (bus.done !== 1'b0) begin
        n_tests++;
        n_fail++;
        $display("FAIL b2b early_done1 cycle=%0d actual=1 required=0", cyc);
      end
      tick();
    end
    bus.start = 1'b0;
    n_tests++;
    if (bus.done !== 1'b1 || outs() !== RES_L) begin
      n_fail++;
      $display("FAIL b2b first done/LEG actual=%b/%b required=1/%b at cycle %0d", bus.done, outs(), RES_L, d1);
    end
    bus.start = 1'b1;
    bus.a = 8'd9;
    bus.b = 8'd9;
    tick();
    bus.start = 1'b0;
    n_tests++;
    if (bus.busy !== 1'b1 || outs() !== RES_L) begin
      n_fail++;
      $display("FAIL b2b second_accept busy/LEG actual=%b/%b required=1/%b", bus.busy, outs(), RES_L);
    end
    while (cyc < d2 && !bus.done) tick();
    n_tests++;
    if (cyc !== d2 || bus.done !== 1'b1 || outs() !== RES_E) begin
      n_fail++;
      $display("FAIL b2b second cycle/done/LEG actual=%0d/%b/%b required=%0d/1/%b", cyc, bus.done, outs(), d2, RES_E);
    end
    tick();
    n_tests++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b idle_after done/busy actual=%b/%b required=0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid();
    int at;
    logic [2:0] r;
    logic busy_ok;
    logic saw_done = 1'b0;
    launch(8'h0F, 8'h0E);
    while (cyc < 5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if ({bus.busy, bus.done, outs()} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_mid outputs actual=%b required=00000", {bus.busy, bus.done, outs()});
    end
    for (int i = 0; i < 2 * WIDTH; i++) begin
      if (bus.done) saw_done = 1'b1;
      tick();
    end
    n_tests++;
    if (saw_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid spurious_done actual=1 required=0");
    end
    launch(8'h21, 8'hC3);
    wait_done(at, r, busy_ok);
    n_tests++;
    if (at !== model_lat(8'h21, 8'hC3) || r !== RES_L) begin
      n_fail++;
      $display("FAIL reset_mid recovery cycle/LEG actual=%0d/%b required=%0d/%b", at, r, model_lat(8'h21, 8'hC3), RES_L);
    end
    tick();
  endtask

  initial begin
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    @(negedge clk);
    test_reset();
    test_directed(8'h5A, 8'h5A, "equal_5a");
    test_directed(8'h80, 8'h7F, "msb_gt");
    test_directed(8'h01, 8'h02, "lsb_lt");
    test_directed(8'h00, 8'hFF, "zero_vs_max");
    test_directed(8'hFE, 8'hFF, "lsb_only_lt");
    test_random(40);
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
